// File: rtl/sisc_mem_arb.sv
// rtl/sisc_mem_arb.sv - shared-memory arbiter and access sequencer for the SISC fetch and data paths
// Serialises fetch and LOD/STR accesses onto the single-ported memory; every output is registered.
module sisc_mem_arb #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int WAIT       = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_n;
  logic [3:0]    wait_cnt, wait_cnt_n;
  logic [2:0]    starve_cnt, starve_cnt_n;
  logic          sel_dm, sel_dm_n;
  logic          sel_we, sel_we_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wdata_n;
  logic          grant;
  logic          finish;

  // mem_addr/mem_wdata double as the latched request, so they stay constant through ACCESS
  always_comb begin
    state_n      = state;
    wait_cnt_n   = wait_cnt;
    starve_cnt_n = starve_cnt;
    sel_dm_n     = sel_dm;
    sel_we_n     = sel_we;
    addr_n       = mem_addr;
    wdata_n      = mem_wdata;
    grant        = 1'b0;
    finish       = 1'b0;
    case (state)
      IDLE: begin
        if (!hold && (if_req || dm_req)) begin
          grant      = 1'b1;
          state_n    = ACCESS;
          wait_cnt_n = 4'(WAIT - 1);
          if (dm_req && !(if_req && starve_cnt == 3'(STARVE_MAX))) begin
            sel_dm_n = 1'b1;
            sel_we_n = dm_we;
            addr_n   = dm_addr;
            wdata_n  = dm_wdata;
            if (if_req) starve_cnt_n = starve_cnt + 3'd1;
          end else begin
            sel_dm_n     = 1'b0;
            sel_we_n     = 1'b0;
            addr_n       = if_addr;
            starve_cnt_n = 3'd0;
          end
        end
      end
      ACCESS: begin
        if (wait_cnt == 4'd0) begin
          finish  = 1'b1;
          state_n = RESP;
        end else begin
          wait_cnt_n = wait_cnt - 4'd1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      starve_cnt <= 3'd0;
      sel_dm     <= 1'b0;
      sel_we     <= 1'b0;
      if_gnt     <= 1'b0;
      dm_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      dm_rvalid  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_cnt_n;
      starve_cnt <= starve_cnt_n;
      sel_dm     <= sel_dm_n;
      sel_we     <= sel_we_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
      if_gnt     <= grant & ~sel_dm_n;
      dm_gnt     <= grant & sel_dm_n;
      if_rvalid  <= finish & ~sel_dm;
      dm_rvalid  <= finish & sel_dm;
      mem_en     <= (state_n == ACCESS);
      mem_we     <= (state_n == ACCESS) & sel_we_n;
      busy       <= (state_n != IDLE);
      if (finish && !sel_we) rdata <= mem_rdata;
    end
  end

endmodule

// File: doc/sisc_mem_arb.md
# sisc_mem_arb

Shared-memory arbiter and access sequencer for the SISC computer. It lets the instruction-fetch path and the data (LOD/STR) path share the single-ported unified memory. The block picks one requester per access, drives the memory port for a fixed number of wait states, captures read data, and returns a one-cycle response. It sits between the `ctrl` FSM / datapath and the memory model.

## Interface
Parameters:
- AW, 16, address width
- DW, 32, data width
- WAIT, 2, memory read latency in cycles from first `mem_en` cycle to `mem_rdata` valid; legal range 1..15
- STARVE_MAX, 3, consecutive fetch losses after which fetch is forced to win; legal range 1..7

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, synchronous and active-high
- hold  in  1  from ctrl (e.g. HLT); blocks new grants, does not abort an in-flight access
- if_req  in  1  fetch request; held high until `if_gnt`
- if_addr  in  AW  fetch address; stable while `if_req` is high
- if_gnt  out  1  one-cycle grant to fetch
- if_rvalid  out  1  one-cycle fetch response
- dm_req  in  1  data request; held high until `dm_gnt`
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  one-cycle grant to data
- dm_rvalid  out  1  one-cycle data response; for a store it is the write acknowledge
- rdata  out  DW  captured read data; shared by both requesters, valid while either rvalid is high
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM has three states:
  - IDLE: arbitrates.
  - ACCESS: drives memory for WAIT cycles.
  - RESP: pulses rvalid for one cycle, then returns to IDLE.
- IDLE:
  - If `hold`=0 and any request is high, latch the winner's id, addr, we and wdata.
  - Load the wait counter with WAIT-1 and go to ACCESS.
  - No other state samples requests.
- Arbitration:
  - A lone requester wins.
  - If both request, data wins unless `starve_cnt`==STARVE_MAX, in which case fetch wins.
  - `starve_cnt` (3 bits) increments when data beats a pending fetch.
  - `starve_cnt` clears whenever fetch is granted.
- ACCESS:
  - `mem_en`=1; `mem_addr`, `mem_we` and `mem_wdata` come from the latched registers, constant for all WAIT cycles.
  - The winner's gnt is high only in the first ACCESS cycle.
  - The counter decrements each cycle.
  - When the counter is 0: capture `mem_rdata` into `rdata` for a load or fetch (stores leave `rdata` unchanged), then go to RESP.
- Stores: `mem_we`=1 for all ACCESS cycles; the write is committed when ACCESS ends.
- Fetch requests are always reads; `mem_we`=0.
- RESP: the winner's rvalid=1 for one cycle, then IDLE.
- A requester may drop req in the cycle after its gnt. A req still high after gnt is treated as a new request at the next IDLE.

## Timing
- All outputs are registered.
- Reset values: `if_gnt`, `dm_gnt`, `if_rvalid`, `dm_rvalid`, `mem_en`, `mem_we`, `busy` = 0. `rdata`, `mem_addr`, `mem_wdata` = 0. State = IDLE. `starve_cnt` = 0. Wait counter = 0.
- Latency: req sampled in IDLE at cycle 0 gives gnt and first `mem_en` at cycle 1, data capture at cycle WAIT, rvalid at cycle WAIT+1, IDLE at cycle WAIT+2.
- Back-to-back throughput is one access per WAIT+2 cycles.
- `hold` is sampled only in IDLE. `hold` rising during ACCESS or RESP lets that access finish, including its rvalid.
- `rst` mid-access: the next edge returns to IDLE with all outputs 0. No rvalid is issued. A store may be partially applied; the requester must reissue it.
- Both reqs arriving in the same cycle as RESP are not seen until the following IDLE cycle.
- rvalid and gnt are never high for both requesters in the same cycle.
- `mem_en` is never high in IDLE or RESP.

## Test plan
- Reset: assert `rst` 2 cycles with both reqs high. All outputs stay 0; first gnt appears exactly 1 cycle after `rst` falls.
- Single fetch, WAIT=2: `if_addr`=0x0010 with `mem_rdata`=0xDEADBEEF. `if_gnt` at cycle 1, `mem_en` at cycles 1-2, `if_rvalid`=1 and `rdata`=0xDEADBEEF at cycle 3, `busy` low at cycle 4.
- Store: `dm_we`=1, addr 0x0020, wdata 0x12345678. `mem_we`=1 for exactly 2 cycles with stable addr/data; `dm_rvalid` pulses at cycle 3; `rdata` unchanged.
- Starvation, STARVE_MAX=3: hold both reqs high continuously. Grant order is D, D, D, F, D, D, D, F, and each grant is WAIT+2 cycles apart.
- Hold: raise `hold` during an ACCESS. That access completes with rvalid; no further gnt while `hold`=1; grant resumes 1 cycle after `hold` falls.
- Reset mid-access: assert `rst` in the second ACCESS cycle. No rvalid follows, `mem_en`=0 next cycle, and `starve_cnt` is cleared (verified by the subsequent D, D, D, F grant sequence).
